// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Full throughput under backpressure; synchronous flush squashes everything held.
module pipe_skid_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             xfer;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;
    assign count  = state;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state     <= EMPTY;
            out_data  <= RESET_VALUE;
            skid_data <= RESET_VALUE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (xfer && accept) begin
                        out_data <= in_data;
                    end else if (xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        skid_data <= in_data;
                        state     <= SKID;
                        in_ready  <= 1'b0;
                    end
                end
                SKID: begin
                    if (xfer) begin
                        out_data <= skid_data;
                        state    <= FULL;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    // unreachable encoding: fall back to a clean empty stage
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks for pipe_skid_reg.
// Two instances: default 32-bit, and 8-bit with a non-zero reset value.
module tb_pipe_skid_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_out_data;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pipe_skid_reg dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    pipe_skid_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'h13)
    ) dut8 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] exp;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        b_in_valid = 1'b1;
        b_in_data  = 8'hEE;
        exp = {1'b0, 1'b1, 2'd0, 32'h0};
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({out_valid, in_ready, count, out_data} !== exp) begin
                n_fail++;
                $display("FAIL reset_cyc%0d got=%h want=%h", i,
                         {out_valid, in_ready, count, out_data}, exp);
            end
            n_checks++;
            if ({b_out_valid, b_in_ready, b_count, b_out_data} !== 12'h413) begin
                n_fail++;
                $display("FAIL reset8_cyc%0d got=%h want=413", i,
                         {b_out_valid, b_in_ready, b_count, b_out_data});
            end
        end
        reset      = 1'b0;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({out_valid, in_ready, count, out_data} !== exp) begin
                n_fail++;
                $display("FAIL idle_cyc%0d got=%h want=%h", i,
                         {out_valid, in_ready, count, out_data}, exp);
            end
        end
    endtask

    task automatic test_stream();
        logic [35:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
            exp = {1'b1, 1'b1, 2'd1, 32'(i)};
            n_checks++;
            if ({out_valid, in_ready, count, out_data} !== exp) begin
                n_fail++;
                $display("FAIL stream_%0d got=%h want=%h", i,
                         {out_valid, in_ready, count, out_data}, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        exp = {1'b0, 1'b1, 2'd0, 32'h4};
        n_checks++;
        if ({out_valid, in_ready, count, out_data} !== exp) begin
            n_fail++;
            $display("FAIL stream_drain got=%h want=%h",
                     {out_valid, in_ready, count, out_data}, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp [7];
        exp[0] = {1'b1, 1'b1, 2'd1, 32'hA};
        exp[1] = {1'b1, 1'b0, 2'd2, 32'hA};
        exp[2] = {1'b1, 1'b0, 2'd2, 32'hA};
        exp[3] = {1'b1, 1'b0, 2'd2, 32'hA};
        exp[4] = {1'b1, 1'b1, 2'd1, 32'hB};
        exp[5] = {1'b1, 1'b1, 2'd1, 32'hC};
        exp[6] = {1'b0, 1'b1, 2'd0, 32'hC};
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid  = (i < 6);
            in_data   = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
            out_ready = (i >= 4);
            tick();
            n_checks++;
            if ({out_valid, in_ready, count, out_data} !== exp[i]) begin
                n_fail++;
                $display("FAIL skid_step%0d got=%h want=%h", i,
                         {out_valid, in_ready, count, out_data}, exp[i]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [35:0] exp;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        exp = {1'b1, 1'b0, 2'd2, 32'h11};
        n_checks++;
        if ({out_valid, in_ready, count, out_data} !== exp) begin
            n_fail++;
            $display("FAIL flush_setup got=%h want=%h",
                     {out_valid, in_ready, count, out_data}, exp);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h33;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp = {1'b0, 1'b1, 2'd0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({out_valid, in_ready, count, out_data} !== exp) begin
                n_fail++;
                $display("FAIL flush_cyc%0d got=%h want=%h", i,
                         {out_valid, in_ready, count, out_data}, exp);
            end
            tick();
        end
        b_in_valid = 1'b1;
        b_in_data  = 8'h77;
        tick();
        b_in_valid = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({b_out_valid, b_in_ready, b_count, b_out_data} !== 12'h413) begin
            n_fail++;
            $display("FAIL flush8 got=%h want=413",
                     {b_out_valid, b_in_ready, b_count, b_out_data});
        end
    endtask

    task automatic test_reset_over_flush();
        out_ready   = 1'b0;
        b_out_ready = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h55;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h55;
        tick();
        n_checks++;
        if ({count, out_data, b_count, b_out_data} !== {2'd1, 32'h55, 2'd1, 8'h55}) begin
            n_fail++;
            $display("FAIL rof_setup got=%h/%h %h/%h want=1/55 1/55",
                     count, out_data, b_count, b_out_data);
        end
        reset   = 1'b1;
        flush   = 1'b1;
        in_data = 32'h66;
        tick();
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, count, out_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL rof32 got=%h want=400000000",
                     {out_valid, in_ready, count, out_data});
        end
        n_checks++;
        if ({b_out_valid, b_in_ready, b_count, b_out_data} !== 12'h413) begin
            n_fail++;
            $display("FAIL rof8 got=%h want=413",
                     {b_out_valid, b_in_ready, b_count, b_out_data});
        end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] mdata;
        logic [35:0] exp;
        logic        hold_req;
        logic [31:0] hold_data;
        logic        acc;
        logic        xfr;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdata = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            in_data   = $urandom;
            flush     = ($urandom_range(0, 49) == 0);
            hold_req  = out_valid && !out_ready && !flush;
            hold_data = out_data;
            if (flush) begin
                q.delete();
                mdata = '0;
            end else begin
                xfr = (q.size() > 0) && out_ready;
                acc = in_valid && (q.size() < 2);
                if (xfr) void'(q.pop_front());
                if (acc) q.push_back(in_data);
                if (q.size() > 0) mdata = q[0];
            end
            tick();
            exp = {q.size() > 0, q.size() < 2, 2'(q.size()), mdata};
            n_checks++;
            if ({out_valid, in_ready, count, out_data} !== exp) begin
                n_fail++;
                $display("FAIL rand_c%0d got=%h want=%h", c,
                         {out_valid, in_ready, count, out_data}, exp);
            end
            if (hold_req) begin
                n_checks++;
                if ({out_valid, out_data} !== {1'b1, hold_data}) begin
                    n_fail++;
                    $display("FAIL rand_hold_c%0d got=%h want=%h", c,
                             {out_valid, out_data}, {1'b1, hold_data});
                end
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_over_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
